panel_status_reporter: RTL and testbench



---
 rtl/panel_status_reporter.sv | 192 +++++++++++++++++++
 tb/tb_panel_status_reporter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_status_reporter.sv
// Purpose: mirrors live control state (emergency/security/ECO/AC/person count) to the remote panel as uart_tx command bytes; optional 0xF0 heartbeat under `define PANEL_TX_HEARTBEAT_EN.
// Latency: a pending change seen in IDLE at cycle N pulses uart_tx_start at N+1; one IDLE cycle separates back-to-back bytes.
// Backpressure: one byte in flight, held until uart_tx_done or TX_TIMEOUT expiry (then re-arbitrated without a shadow update).
module panel_status_reporter #(
    parameter int PC_WIDTH         = 8,
    parameter int TX_TIMEOUT       = 200000,
    parameter int HEARTBEAT_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                emergency_valid,
    input  logic                ECO_mod_valid,
    input  logic                security_valid,
    input  logic [1:0]          ac_working_mode,
    input  logic [PC_WIDTH-1:0] person_count,
    input  logic                uart_tx_done,
    output logic                uart_tx_start,
    output logic [7:0]          uart_tx_data,
    output logic                reporter_busy,
    output logic                in_sync
);

    if (PC_WIDTH < 5 || TX_TIMEOUT < 1 || HEARTBEAT_CYCLES < 1) begin : g_bad_params
        $error("panel_status_reporter: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;
    typedef enum logic [2:0] {IT_EMG, IT_SEC, IT_ECO, IT_AC, IT_PC, IT_HB} item_t;

    localparam int TW = $clog2(TX_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);
    localparam logic signed [PC_WIDTH-1:0] D_MAX = PC_WIDTH'(7);
    localparam logic signed [PC_WIDTH-1:0] D_MIN = PC_WIDTH'(-8);

    state_t state, state_nxt;

    logic                sh_emg, sh_eco, sh_sec;
    logic [1:0]          sh_ac;
    logic [PC_WIDTH-1:0] sh_pc;

    item_t               lat_item;
    logic [3:0]          lat_pay;
    logic [7:0]          tx_byte;
    logic [TW-1:0]       tmo_cnt;
    logic                in_sync_q;

    logic                       pend_emg, pend_sec, pend_eco, pend_ac, pend_pc, any_pend;
    logic signed [PC_WIDTH-1:0] pc_diff;
    logic [3:0]                 pc_delta;
    item_t                      sel_item;
    logic [3:0]                 sel_pay;
    logic                       hb_fire;

    function automatic logic [3:0] opcode(input item_t it);
        case (it)
            IT_EMG:  return 4'h1;
            IT_SEC:  return 4'h7;
            IT_ECO:  return 4'h0;
            IT_AC:   return 4'hA;
            IT_PC:   return 4'hC;
            default: return 4'hF;
        endcase
    endfunction

    // Modular difference read as signed matches the decoder's sign-extended add.
    assign pc_diff  = person_count - sh_pc;
    assign pend_emg = emergency_valid != sh_emg;
    assign pend_sec = security_valid != sh_sec;
    assign pend_eco = ECO_mod_valid != sh_eco;
    assign pend_ac  = ac_working_mode != sh_ac;
    assign pend_pc  = pc_diff != '0;
    assign any_pend = pend_emg | pend_sec | pend_eco | pend_ac | pend_pc;

    always_comb begin
        if (pc_diff > D_MAX)      pc_delta = 4'h7;
        else if (pc_diff < D_MIN) pc_delta = 4'h8;
        else                      pc_delta = pc_diff[3:0];
    end

    always_comb begin
        sel_item = IT_PC;
        sel_pay  = pc_delta;
        if (pend_emg) begin
            sel_item = IT_EMG;
            sel_pay  = {3'b000, emergency_valid};
        end else if (pend_sec) begin
            sel_item = IT_SEC;
            sel_pay  = {3'b000, security_valid};
        end else if (pend_eco) begin
            sel_item = IT_ECO;
            sel_pay  = {3'b000, ECO_mod_valid};
        end else if (pend_ac) begin
            sel_item = IT_AC;
            sel_pay  = {2'b00, ac_working_mode};
        end
    end

`ifdef PANEL_TX_HEARTBEAT_EN
    localparam int HW = $clog2(HEARTBEAT_CYCLES + 1);
    logic [HW-1:0] hb_cnt;

    assign hb_fire = (state == S_IDLE) && !any_pend && (hb_cnt == HW'(HEARTBEAT_CYCLES - 1));

    // Leaving quiet IDLE for any reason (send, pending item) restarts the idle count.
    always_ff @(posedge clk) begin
        if (reset)
            hb_cnt <= '0;
        else if (state == S_IDLE && !any_pend && !hb_fire)
            hb_cnt <= hb_cnt + 1'b1;
        else
            hb_cnt <= '0;
    end
`else
    assign hb_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        uart_tx_start = 1'b0;
        reporter_busy = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_pend || hb_fire) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                uart_tx_start = 1'b1;
                reporter_busy = 1'b1;
                state_nxt     = S_WAIT;
            end
            S_WAIT: begin
                reporter_busy = 1'b1;
                if (uart_tx_done || tmo_cnt == TMO_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_emg    <= 1'b0;
            sh_eco    <= 1'b0;
            sh_sec    <= 1'b0;
            sh_ac     <= 2'b00;
            sh_pc     <= '0;
            lat_item  <= IT_EMG;
            lat_pay   <= 4'h0;
            tx_byte   <= 8'h00;
            tmo_cnt   <= '0;
            in_sync_q <= 1'b0;
        end else begin
            in_sync_q <= (state == S_IDLE) && !any_pend;
            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        lat_item <= sel_item;
                        lat_pay  <= sel_pay;
                        tx_byte  <= {opcode(sel_item), sel_pay};
                    end else if (hb_fire) begin
                        lat_item <= IT_HB;
                        lat_pay  <= 4'h0;
                        tx_byte  <= 8'hF0;
                    end
                end
                S_LOAD: tmo_cnt <= '0;
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Shadow takes the value actually sent, not the current live input.
                    if (uart_tx_done) begin
                        case (lat_item)
                            IT_EMG:  sh_emg <= lat_pay[0];
                            IT_SEC:  sh_sec <= lat_pay[0];
                            IT_ECO:  sh_eco <= lat_pay[0];
                            IT_AC:   sh_ac  <= lat_pay[1:0];
                            IT_PC:   sh_pc  <= sh_pc + {{(PC_WIDTH-4){lat_pay[3]}}, lat_pay};
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign uart_tx_data = tx_byte;
    assign in_sync      = in_sync_q;

endmodule

// File: tb/tb_panel_status_reporter.sv
// Bench for panel_status_reporter: randomized and directed stimulus against a behavioural mirror model.
module tb_panel_status_reporter;
    localparam int PCW   = 8;
    localparam int PCM   = 1 << PCW;
    localparam int TX_TO = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           emergency_valid = 1'b0;
    logic           ECO_mod_valid = 1'b0;
    logic           security_valid = 1'b0;
    logic [1:0]     ac_working_mode = 2'b00;
    logic [PCW-1:0] person_count = '0;
    logic           resp_done = 1'b0;
    logic           spur_done = 1'b0;
    logic           uart_tx_done;
    logic           uart_tx_start;
    logic [7:0]     uart_tx_data;
    logic           reporter_busy;
    logic           in_sync;

    assign uart_tx_done = resp_done | spur_done;

    panel_status_reporter #(.PC_WIDTH(PCW), .TX_TIMEOUT(TX_TO), .HEARTBEAT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .emergency_valid(emergency_valid), .ECO_mod_valid(ECO_mod_valid),
        .security_valid(security_valid), .ac_working_mode(ac_working_mode),
        .person_count(person_count), .uart_tx_done(uart_tx_done),
        .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
        .reporter_busy(reporter_busy), .in_sync(in_sync)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference model: what the far end believes, and the byte currently on the wire.
    bit  m_emg, m_sec, m_eco;
    int  m_ac, m_pc;
    bit  inflight, exp_sync, exp_start, commit_seen;
    int  k, fl_item, fl_pay, fl_byte, cyc;
    bit  s_emg, s_sec, s_eco;
    int  s_ac, s_pc;
    int  resp_delay = 20;
    int  resp_cd = -1;
    logic [7:0] sent_q[$];
    int  start_cyc_q[$];

    function automatic int pc_delta(input int live, input int sh);
        int d = (live - sh + PCM) % PCM;
        if (d >= PCM / 2) d -= PCM;
        if (d > 7) d = 7;
        if (d < -8) d = -8;
        return d;
    endfunction

    function automatic bit live_pending();
        return (emergency_valid != m_emg) || (security_valid != m_sec) || (ECO_mod_valid != m_eco)
            || (int'(ac_working_mode) != m_ac) || (int'(person_count) != m_pc);
    endfunction

    // item: 0 none, 1 emergency, 2 security, 3 ECO, 4 AC, 5 person count
    task automatic pick(output int item, output int pay);
        item = 0; pay = 0;
        if (s_emg != m_emg)      begin item = 1; pay = int'(s_emg); end
        else if (s_sec != m_sec) begin item = 2; pay = int'(s_sec); end
        else if (s_eco != m_eco) begin item = 3; pay = int'(s_eco); end
        else if (s_ac != m_ac)   begin item = 4; pay = s_ac; end
        else if (s_pc != m_pc)   begin item = 5; pay = pc_delta(s_pc, m_pc); end
    endtask

    function automatic int byte_of(input int item, input int pay);
        case (item)
            1: return 'h10 + pay;
            2: return 'h70 + pay;
            3: return pay;
            4: return 'hA0 + pay;
            5: return 'hC0 + (pay & 15);
            default: return 'h1FF;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        commit_seen = 0;
        if (reset) begin
            m_emg = 0; m_sec = 0; m_eco = 0; m_ac = 0; m_pc = 0;
            inflight = 0; exp_sync = 0; exp_start = 0;
        end else begin
            exp_sync  = !inflight && !live_pending();
            exp_start = !inflight && live_pending();
            if (inflight) begin
                k++;
                if (k >= 2 && uart_tx_done) begin
                    case (fl_item)
                        1: m_emg = fl_pay[0];
                        2: m_sec = fl_pay[0];
                        3: m_eco = fl_pay[0];
                        4: m_ac  = fl_pay;
                        5: m_pc  = (m_pc + fl_pay + PCM) % PCM;
                        default: ;
                    endcase
                    inflight = 0;
                    commit_seen = 1;
                end else if (k == TX_TO + 1) begin
                    inflight = 0;
                end
            end
        end
        s_emg = emergency_valid; s_sec = security_valid; s_eco = ECO_mod_valid;
        s_ac = int'(ac_working_mode); s_pc = int'(person_count);
    end

    initial begin
        int it, pay, b;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (commit_seen) chk("data_held", uart_tx_data, fl_byte);
            chk("in_sync", in_sync, exp_sync);
            chk("start", uart_tx_start, exp_start);
            if (uart_tx_start) begin
                pick(it, pay);
                b = byte_of(it, pay);
                chk("tx_byte", uart_tx_data, b);
                sent_q.push_back(uart_tx_data);
                start_cyc_q.push_back(cyc);
                inflight = 1; k = 0; fl_item = it; fl_pay = pay; fl_byte = b;
            end
            chk("busy", reporter_busy, inflight);
        end
    end

    // Far-end uart_tx: done pulse resp_delay cycles after each start (negative = never).
    initial forever begin
        @(negedge clk);
        resp_done = 1'b0;
        if (uart_tx_start) resp_cd = resp_delay;
        else if (resp_cd > 0) resp_cd--;
        if (resp_cd == 0) begin
            resp_done = 1'b1;
            resp_cd = -1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        emergency_valid = 0; security_valid = 0; ECO_mod_valid = 0;
        ac_working_mode = 0; person_count = 0;
        tick(2);
        chk("rst_start", uart_tx_start, 0);
        chk("rst_data", uart_tx_data, 8'h00);
        chk("rst_busy", reporter_busy, 0);
        chk("rst_in_sync", in_sync, 0);
        reset = 1'b0;
        sent_q.delete();
        start_cyc_q.delete();
    endtask

    task automatic quiesce(input string tag);
        int n = 0;
        int stable = 0;
        while (n < 3000 && stable < 3) begin
            tick(1);
            n++;
            if (!inflight && !live_pending()) stable++;
            else stable = 0;
        end
        chk({tag, "_quiesce"}, stable >= 3, 1);
        chk({tag, "_in_sync"}, in_sync, 1);
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        int c = 0;
        while (sent_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        chk({tag, "_start_seen"}, sent_q.size() >= n, 1);
    endtask

    task automatic expect_seq(input string tag, input int n, input logic [63:0] bytes);
        logic [7:0] e;
        chk({tag, "_count"}, sent_q.size(), n);
        for (int i = 0; i < n && i < sent_q.size(); i++) begin
            e = bytes[8*(n-1-i) +: 8];
            chk($sformatf("%s_byte%0d", tag, i), sent_q[i], e);
        end
        sent_q.delete();
        start_cyc_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        tick(3);

        // All items at once, sent in priority order.
        resp_delay = 20;
        emergency_valid = 1; security_valid = 1; ECO_mod_valid = 1;
        ac_working_mode = 2'b10; person_count = 3;
        wait_starts("t1", 5, 400);
        for (int i = 1; i < 5 && i < start_cyc_q.size(); i++)
            chk($sformatf("t1_gap%0d", i), start_cyc_q[i] - start_cyc_q[i-1], 22);
        quiesce("t1");
        expect_seq("t1", 5, 64'h11_71_01_A2_C3);

        // Person count clamping, both directions, and modular wrap.
        do_reset();
        person_count = 20;
        quiesce("t2a");
        expect_seq("t2a", 3, 64'hC7_C7_C6);
        person_count = 5;
        quiesce("t2b");
        expect_seq("t2b", 2, 64'hC8_C9);
        person_count = 250;
        quiesce("t3a");
        sent_q.delete();
        person_count = 4;
        quiesce("t3b");
        expect_seq("t3b", 2, 64'hC7_C3);

        // done outside WAIT must not disturb anything.
        spur_done = 1; tick(1); spur_done = 0;
        tick(10);
        chk("spur_no_byte", sent_q.size(), 0);
        chk("spur_in_sync", in_sync, 1);

        // Timeout and re-arbitration of the same item.
        do_reset();
        resp_delay = -1;
        emergency_valid = 1;
        wait_starts("t4a", 1, 50);
        resp_delay = 5;
        wait_starts("t4b", 2, TX_TO + 20);
        if (start_cyc_q.size() >= 2)
            chk("t4_retry_gap", start_cyc_q[1] - start_cyc_q[0], TX_TO + 2);
        quiesce("t4");
        expect_seq("t4", 2, 64'h11_11);

        // Input change while a byte is in flight.
        do_reset();
        resp_delay = 20;
        ECO_mod_valid = 1;
        wait_starts("t5", 1, 50);
        tick(3);
        ac_working_mode = 2'b11;
        quiesce("t5");
        expect_seq("t5", 2, 64'h01_A3);

        // Reset in the middle of WAIT.
        do_reset();
        emergency_valid = 1; security_valid = 1; ac_working_mode = 2'b01; person_count = 9;
        wait_starts("t6", 1, 50);
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_start", uart_tx_start, 0);
        chk("t6_rst_busy", reporter_busy, 0);
        tick(1);
        reset = 1'b0;
        quiesce("t6");
        expect_seq("t6", 6, 64'h11_11_71_A1_C7_C2);

        // Random stimulus; every byte is checked by the model.
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 7))
                0:       resp_delay = 80;
                1:       resp_delay = 0;
                default: resp_delay = $urandom_range(1, 25);
            endcase
            for (int c = 0; c < 50; c++) begin
                tick(1);
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 5))
                        0: emergency_valid = ~emergency_valid;
                        1: security_valid = ~security_valid;
                        2: ECO_mod_valid = ~ECO_mod_valid;
                        3: ac_working_mode = 2'($urandom_range(0, 3));
                        4: person_count = PCW'($urandom_range(0, PCM - 1));
                        default: person_count = person_count + PCW'($urandom_range(0, 6)) - PCW'(3);
                    endcase
                end
            end
            if (seg % 15 == 14) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
        end
        resp_delay = 3;
        quiesce("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
